// File: rtl/vit_tb_ctrl_pkg.sv
// vit_tb_ctrl_pkg: shared sizes, FSM encoding and pointer wrap helpers for the survivor sequencer.
// VIT_PARTIAL_FLUSH_EN adds the PEND state used by partial-block flush.
package vit_tb_ctrl_pkg;
  localparam int BLOCK_LEN = 20;
  localparam int PTR_W = 6;
  localparam int CNT_W = 5;
  localparam logic [PTR_W-1:0] BANK0_BASE = '0;
  localparam logic [PTR_W-1:0] BANK1_BASE = PTR_W'(BLOCK_LEN);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(2*BLOCK_LEN-1);
`ifdef VIT_PARTIAL_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACE = 2'd1, S_PEND = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACE = 2'd1} state_e;
`endif
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction
  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_MAX : p - 1'b1;
  endfunction
endpackage

// File: rtl/vit_tb_ctrl_if.sv
// vit_tb_ctrl_if: decoder-side handshake and survivor-memory addressing bundle.
interface vit_tb_ctrl_if;
  import vit_tb_ctrl_pkg::*;
  logic             rx_valid;
  logic             flush;
  logic             we;
  logic [PTR_W-1:0] write_ptr;
  logic [CNT_W-1:0] block_count;
  logic             te;
  logic [PTR_W-1:0] trace_ptr;
  logic             tb_load;
  logic             oe;
  logic             oe_last;
  logic             busy;
  logic             err;
  modport master (output rx_valid, flush,
                  input  we, write_ptr, block_count, te, trace_ptr, tb_load, oe, oe_last, busy, err);
  modport slave  (input  rx_valid, flush,
                  output we, write_ptr, block_count, te, trace_ptr, tb_load, oe, oe_last, busy, err);
endinterface

// File: rtl/vit_tb_ctrl_addr_gen.sv
// vit_tb_addr_gen: loadable traceback down-counter with remaining-length count and last flag.
module vit_tb_addr_gen
  import vit_tb_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             last_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  // pointer parks on the bank base once the final read has been issued
  always_comb begin
    ptr_d = load_i ? ptr_i : (len_q > CNT_W'(1)) ? ptr_dec(ptr_q) : ptr_q;
    len_d = load_i ? len_i : (clr_i || len_q == '0) ? '0 : len_q - 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ptr_q <= '0;
      len_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      len_q <= len_d;
    end
  assign ptr_o  = ptr_q;
  assign last_o = len_q == CNT_W'(1);
endmodule

// File: rtl/vit_tb_ctrl.sv
// vit_tb_ctrl: ping-pong survivor memory write/traceback sequencer for the (2,1,3) Viterbi decoder.
// VIT_PARTIAL_FLUSH_EN enables traceback of a partial block on flush (PEND, busy, err).
module vit_tb_ctrl
  import vit_tb_ctrl_pkg::*;
(
  input logic         clk_i,
  input logic         rst_ni,
  vit_tb_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [PTR_W-1:0] write_ptr_q, write_ptr_d, ld_ptr, trace_ptr, wbase, pend_ptr;
  logic [CNT_W-1:0] block_count_q, block_count_d, ld_len, pend_len;
  logic we, req, wflush, abort, part_flush, pend, load, te, last;
  logic tb_load_q, oe_q, oe_last_q;
  assign req = we && block_count_q == CNT_W'(BLOCK_LEN-1);
`ifdef VIT_PARTIAL_FLUSH_EN
  logic busy_q, busy_d, err_q, part_q, part_d, part_last_q;
  logic [PTR_W-1:0] pend_ptr_q;
  logic [CNT_W-1:0] pend_len_q;
  assign we         = bus.rx_valid && !bus.flush && !busy_q;
  assign part_flush = bus.flush && block_count_q != '0;
  assign wflush     = part_flush;
  assign wbase      = (write_ptr_q < BANK1_BASE) ? BANK1_BASE : BANK0_BASE;
  assign abort      = 1'b0;
  assign pend_ptr   = pend_ptr_q;
  assign pend_len   = pend_len_q;
  always_comb begin
    part_d = load ? (part_flush || pend) : part_q;
    busy_d = part_flush ? 1'b1 : part_last_q ? 1'b0 : busy_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      part_q      <= 1'b0;
      part_last_q <= 1'b0;
      pend_ptr_q  <= '0;
      pend_len_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      err_q       <= bus.rx_valid && busy_q;
      part_q      <= part_d;
      part_last_q <= te && last && part_q;
      pend_ptr_q  <= part_flush ? ptr_dec(write_ptr_q) : pend_ptr_q;
      pend_len_q  <= part_flush ? block_count_q : pend_len_q;
    end
  assign bus.busy = busy_q;
  assign bus.err  = err_q;
`else
  assign we         = bus.rx_valid && !bus.flush;
  assign part_flush = 1'b0;
  assign wflush     = bus.flush;
  assign wbase      = BANK0_BASE;
  assign abort      = bus.flush;
  assign pend_ptr   = '0;
  assign pend_len   = '0;
  assign bus.busy   = 1'b0;
  assign bus.err    = 1'b0;
`endif
  always_comb begin
    write_ptr_d   = wflush ? wbase : we ? ptr_inc(write_ptr_q) : write_ptr_q;
    block_count_d = (wflush || req) ? '0 : we ? block_count_q + 1'b1 : block_count_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (req || part_flush) ? S_TRACE : S_IDLE;
`ifdef VIT_PARTIAL_FLUSH_EN
      S_TRACE: state_d = last ? ((req || part_flush) ? S_TRACE : S_IDLE) : part_flush ? S_PEND : S_TRACE;
      S_PEND:  state_d = last ? S_TRACE : S_PEND;
`else
      S_TRACE: state_d = (abort || (last && !req)) ? S_IDLE : S_TRACE;
`endif
      default: state_d = S_IDLE;
    endcase
  end
  // a new trace loads from idle, or seamlessly on the final read of the current one
  always_comb begin
`ifdef VIT_PARTIAL_FLUSH_EN
    pend = state_q == S_PEND;
`else
    pend = 1'b0;
`endif
    te     = state_q != S_IDLE;
    load   = (req || part_flush || pend) && (state_q == S_IDLE || last);
    ld_ptr = part_flush ? ptr_dec(write_ptr_q) : pend ? pend_ptr : write_ptr_q;
    ld_len = part_flush ? block_count_q : pend ? pend_len : CNT_W'(BLOCK_LEN);
  end
  vit_tb_addr_gen u_addr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .clr_i  (abort),
    .ptr_i  (ld_ptr),
    .len_i  (ld_len),
    .ptr_o  (trace_ptr),
    .last_o (last)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      write_ptr_q   <= '0;
      block_count_q <= '0;
      tb_load_q     <= 1'b0;
      oe_q          <= 1'b0;
      oe_last_q     <= 1'b0;
    end else begin
      write_ptr_q   <= write_ptr_d;
      block_count_q <= block_count_d;
      tb_load_q     <= load;
      oe_q          <= te;
      oe_last_q     <= te && last;
    end
  assign bus.we          = we;
  assign bus.write_ptr   = write_ptr_q;
  assign bus.block_count = block_count_q;
  assign bus.te          = te;
  assign bus.trace_ptr   = trace_ptr;
  assign bus.tb_load     = tb_load_q;
  assign bus.oe          = oe_q;
  assign bus.oe_last     = oe_last_q;
endmodule

// File: tb/tb_vit_tb_ctrl.sv
// tb_vit_tb_ctrl: directed cycle-by-cycle bench for the survivor-memory sequencer.
module tb_vit_tb_ctrl;
  import vit_tb_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  vit_tb_ctrl_if bus();
  vit_tb_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [22:0] pack(input logic te, tl, oe, ol, busy, err, input int wp, bc, tp);
    return {te, tl, oe, ol, busy, err, PTR_W'(wp), CNT_W'(bc), PTR_W'(tp)};
  endfunction
  // trace_ptr is only meaningful while te is expected high
  function automatic logic [22:0] observed(input logic mask);
    return {bus.te, bus.tb_load, bus.oe, bus.oe_last, bus.busy, bus.err,
            bus.write_ptr, bus.block_count, mask ? bus.trace_ptr : 6'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] got, exp;
    rst_n = 1'b0;
    bus.rx_valid = 1'b1;
    bus.flush = 1'b0;
    tick();
    got = observed(1'b1);
    exp = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_outputs got %h exp %h", got, exp); end
    n_cmp++;
    if (bus.we !== 1'b1) begin n_err++; $display("FAIL reset_we_follows got %b exp 1", bus.we); end
    bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.we !== 1'b0) begin n_err++; $display("FAIL reset_we_flush got %b exp 0", bus.we); end
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_stream(input int n);
    logic [22:0] got, exp;
    int t, last_c, k, j;
    logic te_e, oe_e;
    int blk [40];
    t = n / 20;
    last_c = 20 * t + 22;
    for (int a = 0; a < 40; a++) blk[a] = -1;
    apply_reset();
    for (int c = 1; c <= last_c; c++) begin
      te_e = c >= 21 && c <= 20 + 20 * t;
      oe_e = c >= 22 && c <= 21 + 20 * t;
      k = te_e ? (c - 21) / 20 : 0;
      j = te_e ? (c - 21) % 20 : 0;
      exp = pack(te_e, te_e && j == 0, oe_e, oe_e && (c - 22) % 20 == 19, 0, 0,
                 c <= n + 1 ? (c - 1) % 40 : n % 40, c <= n + 1 ? (c - 1) % 20 : 0,
                 te_e ? (k % 2) * 20 + 19 - j : 0);
      got = observed(te_e);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL stream%0d c=%0d got %h exp %h", n, c, got, exp); end
      if (te_e && bus.trace_ptr < 40) begin
        n_cmp++;
        if (blk[bus.trace_ptr] !== k) begin
          n_err++;
          $display("FAIL stream%0d survivor c=%0d addr %0d holds block %0d exp %0d", n, c, bus.trace_ptr, blk[bus.trace_ptr], k);
        end
      end
      bus.rx_valid = c <= n;
      #1;
      n_cmp++;
      if (bus.we !== (c <= n)) begin n_err++; $display("FAIL stream%0d we c=%0d got %b exp %b", n, c, bus.we, c <= n); end
      if (bus.we && bus.write_ptr < 40) blk[bus.write_ptr] = (c - 1) / 20;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [22:0] got, exp;
    apply_reset();
    bus.rx_valid = 1'b1;
    repeat (29) tick();
    got = observed(1'b1);
    exp = pack(1, 0, 1, 0, 0, 0, 29, 9, 10);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL midreset_before got %h exp %h", got, exp); end
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    got = observed(1'b1);
    exp = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== exp || bus.we !== 1'b0) begin n_err++; $display("FAIL midreset_clear got %h we %b exp %h we 0", got, bus.we, exp); end
    #2 rst_n = 1'b1;
    bus.rx_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.we !== 1'b1 || bus.write_ptr !== 6'd0) begin n_err++; $display("FAIL midreset_first_write we %b ptr %0d exp 1 0", bus.we, bus.write_ptr); end
    tick();
    bus.rx_valid = 1'b0;
    got = observed(1'b0);
    exp = pack(0, 0, 0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL midreset_after got %h exp %h", got, exp); end
  endtask

`ifndef VIT_PARTIAL_FLUSH_EN
  task automatic test_flush();
    logic [22:0] got, exp;
    logic te_e, oe_e;
    apply_reset();
    for (int c = 1; c <= 28; c++) begin
      te_e = c >= 21 && c <= 26;
      oe_e = c >= 22 && c <= 27;
      exp = pack(te_e, c == 21, oe_e, 0, 0, 0, c <= 26 ? c - 1 : 0,
                 c <= 20 ? c - 1 : c <= 26 ? c - 21 : 0, te_e ? 40 - c : 0);
      got = observed(te_e);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL flush c=%0d got %h exp %h", c, got, exp); end
      bus.rx_valid = c <= 26;
      bus.flush = c == 26;
      #1;
      n_cmp++;
      if (bus.we !== (c <= 25)) begin n_err++; $display("FAIL flush we c=%0d got %b exp %b", c, bus.we, c <= 25); end
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_flush_req();
    logic [22:0] got, exp;
    apply_reset();
    for (int c = 1; c <= 22; c++) begin
      exp = pack(0, 0, 0, 0, 0, 0, c <= 20 ? c - 1 : 0, c <= 20 ? c - 1 : 0, 0);
      got = observed(1'b0);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL flush_req c=%0d got %h exp %h", c, got, exp); end
      bus.rx_valid = c <= 20;
      bus.flush = c == 20;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
`else
  task automatic test_partial();
    logic [22:0] got, exp;
    logic te_e;
    apply_reset();
    for (int c = 1; c <= 50; c++) begin
      te_e = c >= 21 && c <= 47;
      exp = pack(te_e, c == 21 || c == 41, c >= 22 && c <= 48, c == 41 || c == 48,
                 c >= 29 && c <= 48, 0, c <= 28 ? c - 1 : c == 50 ? 1 : 0,
                 c <= 20 ? c - 1 : c <= 28 ? c - 21 : c == 50 ? 1 : 0,
                 c <= 40 ? 40 - c : 67 - c);
      got = observed(te_e);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL partial c=%0d got %h exp %h", c, got, exp); end
      bus.rx_valid = c <= 27 || c == 49;
      bus.flush = c == 28;
      #1;
      n_cmp++;
      if (bus.we !== (c <= 27 || c == 49)) begin n_err++; $display("FAIL partial we c=%0d got %b", c, bus.we); end
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_err();
    logic [22:0] got, exp;
    logic te_e;
    apply_reset();
    for (int c = 1; c <= 14; c++) begin
      te_e = c >= 7 && c <= 11;
      exp = pack(te_e, c == 7, c >= 8 && c <= 12, c == 12, c >= 7 && c <= 12, c == 9,
                 c <= 6 ? c - 1 : c == 14 ? 21 : 20, c <= 6 ? c - 1 : c == 14 ? 1 : 0,
                 te_e ? 11 - c : 0);
      got = observed(te_e);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL err c=%0d got %h exp %h", c, got, exp); end
      bus.rx_valid = c <= 5 || c == 8 || c == 13;
      bus.flush = c == 6;
      #1;
      n_cmp++;
      if (bus.we !== (c <= 5 || c == 13)) begin n_err++; $display("FAIL err we c=%0d got %b", c, bus.we); end
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
`endif

  initial begin
    bus.rx_valid = 1'b0;
    bus.flush = 1'b0;
    test_reset();
    test_stream(40);
    test_stream(60);
`ifndef VIT_PARTIAL_FLUSH_EN
    test_flush();
    test_flush_req();
`else
    test_partial();
    test_err();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
